// File: rtl/uart_pkg.sv
// Shared UART constants used by uart_rx, uart_tx and the receive-side byte queue.
// Bit timing is derived from the 50 MHz system clock and the 115200 baud line rate.
package uart_pkg;
    localparam int CLK_HZ       = 50_000_000;
    localparam int BAUD         = 115200;
    localparam int CLKS_PER_BIT = 434;
    localparam int DATA_W       = 8;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the receive byte queue and its neighbours: uart_rx byte strobe in,
// valid/ready read port and status flags out. The master side is the environment, the slave side is the queue.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [uart_pkg::DATA_W-1:0] rx_msg;
    logic                        rx_complete;
    logic [uart_pkg::DATA_W-1:0] rd_data;
    logic                        rd_valid;
    logic                        rd_ready;
    logic [ADDR_W:0]             count;
    logic                        full;
    logic                        overflow;
    logic                        clr_overflow;

    modport master (
        output rx_msg, rx_complete, rd_ready, clr_overflow,
        input  rd_data, rd_valid, count, full, overflow
    );

    modport slave (
        input  rx_msg, rx_complete, rd_ready, clr_overflow,
        output rd_data, rd_valid, count, full, overflow
    );
endinterface

// File: rtl/rx_fifo_mem.sv
// Purpose: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge; read data follows raddr combinationally.
// Backpressure: none; the caller decides when writes are legal.
module rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose: queue bytes announced by uart_rx (one per rx_complete rising edge) for a valid/ready consumer.
// Latency: byte visible on rd_data one cycle after the rx_complete rise; pop takes effect at the edge.
// Backpressure: consumer stalls via rd_ready; writes at full without a pop are dropped and flagged sticky.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic            clk_50M,
    input  logic            rst,
    uart_rx_fifo_if.slave   bus
);
    localparam int              ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic              rx_complete_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;

    logic wr_en;
    logic rd_en;
    logic wr_accept;
    logic wr_drop;
    logic full_w;
    logic rd_valid_w;

    // Flags decode from the counter register only, so rd_ready never reaches an output.
    assign full_w     = (count_q == FULL_CNT);
    assign rd_valid_w = (count_q != '0);

    assign wr_en     = bus.rx_complete & ~rx_complete_d;
    assign rd_en     = rd_valid_w & bus.rd_ready;
    assign wr_accept = wr_en & (~full_w | rd_en);
    assign wr_drop   = wr_en & full_w & ~rd_en;

    // rx_complete_d resets high so a level already present at reset release is not a new byte.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            rx_complete_d <= 1'b1;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            rx_complete_d <= bus.rx_complete;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_accept && !rd_en) begin
                count_q <= count_q + 1'b1;
            end else if (rd_en && !wr_accept) begin
                count_q <= count_q - 1'b1;
            end
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_mem (
        .clk   (clk_50M),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (bus.rx_msg),
        .raddr (rd_ptr),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid = rd_valid_w;
    assign bus.count    = count_q;
    assign bus.full     = full_w;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue model with a scoreboard of expected bytes,
// immediate assertions at every comparison point.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic clk_50M = 1'b0;
    logic rst     = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] sb_q [$];
    int         m_count = 0;
    logic       m_ovf   = 1'b0;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .bus     (bus)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.rx_msg      = b;
        bus.rx_complete = 1'b1;
        if (m_count < DEPTH) begin
            sb_q.push_back(b);
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
        step();
        bus.rx_complete = 1'b0;
        step();
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp_b;
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        exp_b = sb_q.pop_front();
        check({tag, "_data"}, 32'(bus.rd_data), 32'(exp_b));
        m_count--;
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        check({tag, "_count"}, 32'(bus.count), 32'(m_count));
    endtask

    task automatic status_check(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'(m_count));
        check({tag, "_full"}, 32'(bus.full), 32'(m_count == DEPTH));
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'(m_count != 0));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
    endtask

    initial begin
        bus.rx_msg       = 8'h00;
        bus.rx_complete  = 1'b1;
        bus.rd_ready     = 1'b0;
        bus.clr_overflow = 1'b0;

        // Reset values, with rx_complete already high across release.
        #5;
        status_check("reset");
        step(2);
        rst = 1'b0;
        step(4);
        status_check("rc_high_release");
        bus.rx_complete = 1'b0;
        step();

        // rd_ready on an empty queue is ignored.
        bus.rd_ready = 1'b1;
        step(3);
        bus.rd_ready = 1'b0;
        status_check("empty_ready");

        // Single byte held 20 cycles; no bypass in the write cycle.
        bus.rx_msg      = 8'h7F;
        bus.rx_complete = 1'b1;
        #1;
        check("no_bypass_valid", 32'(bus.rd_valid), 32'd0);
        sb_q.push_back(8'h7F);
        m_count = 1;
        step();
        check("single_count_n1", 32'(bus.count), 32'd1);
        check("single_data_n1", 32'(bus.rd_data), 32'h7F);
        step(19);
        check("single_held_count", 32'(bus.count), 32'd1);
        bus.rx_complete = 1'b0;
        step();
        pop_check("single_pop");
        check("single_empty_valid", 32'(bus.rd_valid), 32'd0);

        // Order and pointer wrap with interleaved pops.
        for (int i = 0; i < 20; i++) begin
            write_byte(8'(i));
            if (m_count == 8) begin
                for (int k = 0; k < 4; k++) pop_check("wrap_pop");
            end
        end
        while (sb_q.size() > 0) pop_check("wrap_drain");
        status_check("wrap_end");

        // Overflow: 17 writes with no consumer.
        for (int i = 0; i < 17; i++) write_byte(8'hA0 + 8'(i));
        status_check("ovf_full");
        bus.clr_overflow = 1'b1;
        m_ovf = 1'b0;
        step();
        bus.clr_overflow = 1'b0;
        status_check("ovf_clr");

        // Full with simultaneous write and pop: both happen, count holds.
        bus.rx_msg      = 8'hC5;
        bus.rx_complete = 1'b1;
        bus.rd_ready    = 1'b1;
        check("simul_head", 32'(bus.rd_data), 32'(sb_q.pop_front()));
        sb_q.push_back(8'hC5);
        step();
        bus.rx_complete = 1'b0;
        bus.rd_ready    = 1'b0;
        step();
        status_check("simul");

        // Dropped write and clear in the same cycle: set wins.
        bus.rx_msg       = 8'hEE;
        bus.rx_complete  = 1'b1;
        bus.clr_overflow = 1'b1;
        m_ovf = 1'b1;
        step();
        bus.rx_complete  = 1'b0;
        bus.clr_overflow = 1'b0;
        step();
        status_check("set_wins");
        bus.clr_overflow = 1'b1;
        m_ovf = 1'b0;
        step();
        bus.clr_overflow = 1'b0;

        while (sb_q.size() > 0) pop_check("ovf_drain");
        status_check("ovf_end");

        // Asynchronous reset mid-operation empties the queue at once.
        for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i));
        check("pre_rst_count", 32'(bus.count), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        sb_q.delete();
        m_count = 0;
        status_check("async_rst");
        step();
        rst = 1'b0;
        step(2);
        write_byte(8'h3C);
        pop_check("post_rst_pop");
        status_check("post_rst_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of `uart_rx`: it captures each byte that `uart_rx` announces on `rx_complete` and queues it for a consumer (command parser, loopback, CPU register) through a valid/ready read port. It decouples the 115200-baud serial arrival rate (one byte per ~86.8 µs, 4340 cycles at 50 MHz) from a consumer that may stall. Overruns are flagged, never silently merged.

## Interface
- `DEPTH`, 16, number of byte slots; power of two, ≥2
- `ADDR_W`, log2(DEPTH) = 4, pointer width (derived, not overridden)

- `clk_50M`  in  1  system clock, 50 MHz
- `rst`  in  1  reset, asynchronous, active-high
- `rx_msg`  in  8  byte from `uart_rx`; stable while `rx_complete` high
- `rx_complete`  in  1  byte-done indication from `uart_rx`; level, may stay high many cycles
- `rd_data`  out  8  head-of-queue byte; meaningful only when `rd_valid`=1
- `rd_valid`  out  1  queue non-empty
- `rd_ready`  in  1  consumer accepts `rd_data` this cycle
- `count`  out  ADDR_W+1  bytes currently stored, 0..DEPTH
- `full`  out  1  `count`==DEPTH
- `overflow`  out  1  sticky: a byte was dropped because the queue was full
- `clr_overflow`  in  1  single-cycle clear of `overflow`

## Operation
- Write strobe `wr_en` = `rx_complete` & ~`rx_complete_d` (rising edge; `rx_complete_d` is a register). One byte queued per rising edge regardless of how long `rx_complete` stays high.
- Read handshake `rd_en` = `rd_valid` & `rd_ready`; byte pops at that clock edge.
- Write accepted when `wr_en` & (~`full` | `rd_en`). At full with simultaneous pop, both occur; `count` unchanged.
- Write when `full` & ~`rd_en`: byte discarded, `overflow` set, contents untouched.
- Read when empty: impossible (`rd_valid`=0); `rd_ready` ignored.
- Simultaneous write to an empty queue: no bypass; byte visible next cycle.
- Pointers `wr_ptr`/`rd_ptr` are ADDR_W bits, wrap DEPTH-1 → 0 naturally; `count` is a separate up/down counter: +1 on accepted write only, −1 on pop only, unchanged on both or neither.
- `overflow`: set on dropped write; cleared by `clr_overflow`; set wins if both same cycle.
- Storage array has no reset; only pointers, `count`, `overflow`, `rx_complete_d` reset.

## Timing
- Reset values: `count`=0, `rd_valid`=0, `full`=0, `overflow`=0, `rd_data` don't-care (undefined until first write); `rx_complete_d`=1 so an `rx_complete` already high at reset release produces no write.
- Reset asserted mid-operation: queue emptied immediately (async), in-flight byte lost, no overflow reported.
- Latency: `rx_complete` rises at cycle N → `wr_en` high in N → `rd_valid`=1, `rd_data`=byte, `count` updated in N+1.
- Pop at edge of cycle M → next byte (or `rd_valid`=0) visible in M+1.
- `rd_data` driven from `mem[rd_ptr]`, combinational off registered state; no logic from `rd_ready` to `rd_data`/`rd_valid`.
- All outputs registered or decoded from registers only; no combinational input→output path.

## Structure
- Shared package `uart_pkg`: `CLK_HZ`=50_000_000, `BAUD`=115200, `CLKS_PER_BIT`=434, `DATA_W`=8; `uart_rx`, `uart_tx` and this block import it.
- One sub-module: `rx_fifo_mem` (DEPTH×DATA_W register array, one write port, one async read port). Control, pointers, edge detect and flags stay in `uart_rx_fifo`.

## Test plan
- Single byte: `rx_msg`=8'h7F, `rx_complete` held high 20 cycles → exactly one entry; `count`=1, `rd_data`=8'h7F next cycle; pop → `count`=0, `rd_valid`=0.
- Order and wrap: write 8'h00..8'h13 (20 bytes) interleaved with pops keeping `count`≤8 → popped sequence exactly 8'h00..8'h13, pointers wrapped once.
- Overflow: 17 writes 8'hA0..8'hB0, `rd_ready`=0 → `full`=1, `count`=16, `overflow`=1, drain yields 8'hA0..8'hAF; `clr_overflow` pulse → `overflow`=0.
- Full plus simultaneous write/pop: at `count`=16, `wr_en` with `rd_ready`=1 → both accepted, `count`=16, `overflow` stays 0, new byte emerges last.
- Reset behaviour: `rx_complete`=1 across `rst` release → no entry; assert `rst` with `count`=5 → `count`=0, `rd_valid`=0 immediately.
- End-to-end with `uart_rx`: drive 8'h7F serially at 434 cycles/bit → one entry 8'h7F, `overflow`=0.
